i2s_capture_ctrl: RTL and testbench



---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sample_fmt.sv | 29 ++
 rtl/i2s_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture controller.
// Holds the capture FSM state encoding and the channel-select codes.
package i2s_pkg;

    localparam int I2S_W = 24;

    typedef enum logic [1:0] {IDLE, SYNC, FILL, HOLD} cap_state_t;

    localparam logic [1:0] CH_LEFT  = 2'd0;
    localparam logic [1:0] CH_RIGHT = 2'd1;
    localparam logic [1:0] CH_MONO  = 2'd2;

endpackage

// File: rtl/i2s_sample_fmt.sv
// Combinational channel select, mono average and truncation to the stored width.
module i2s_sample_fmt
    import i2s_pkg::*;
#(
    parameter int IN_W  = I2S_W,
    parameter int OUT_W = 16
) (
    input  logic [1:0]       chan_sel_i,
    input  logic [IN_W-1:0]  left_i,
    input  logic [IN_W-1:0]  right_i,
    output logic [OUT_W-1:0] wdata_o
);

    logic [IN_W:0]   sum;
    logic [IN_W-1:0] sel;

    always_comb begin
        // Sign-extended sum; taking bits [IN_W:1] is the arithmetic shift then truncation.
        sum = {left_i[IN_W-1], left_i} + {right_i[IN_W-1], right_i};
        case (chan_sel_i)
            CH_LEFT:  sel = left_i;
            CH_RIGHT: sel = right_i;
            CH_MONO:  sel = sum[IN_W:1];
            default:  sel = left_i;
        endcase
        wdata_o = sel[IN_W-1 -: OUT_W];
    end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Captures I2S samples into a ping-pong sample RAM and hands full banks to a consumer.
// Optional drop counter output enabled by defining I2S_CAPTURE_DROP_CNT_EN.
module i2s_capture_ctrl
    import i2s_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int ADDR_W    = $clog2(N_SAMPLES),
    parameter int IN_W      = I2S_W,
    parameter int OUT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        chan_sel,
    input  logic              lrck,
    input  logic [IN_W-1:0]   left,
    input  logic [IN_W-1:0]   right,
    output logic              buf_we,
    output logic              buf_bank,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [OUT_W-1:0]  buf_wdata,
    output logic              frame_valid,
    output logic              frame_bank,
    input  logic              frame_ack,
    output logic              overrun
`ifdef I2S_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    cap_state_t        state_q, state_d;
    logic              lrck_q, en_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              bank_q, bank_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wbank_q, wbank_d;
    logic [OUT_W-1:0]  wdata_q, wdata_d;
    logic              fv_q, fv_d;
    logic              fbank_q, fbank_d;
    logic              ovr_q, ovr_d;

    logic              se, en_fall, last, fv_after_ack;
    logic [OUT_W-1:0]  fmt_data;

    i2s_sample_fmt #(.IN_W(IN_W), .OUT_W(OUT_W)) u_fmt (
        .chan_sel_i (chan_sel),
        .left_i     (left),
        .right_i    (right),
        .wdata_o    (fmt_data)
    );

    assign se           = lrck_q & ~lrck;
    assign en_fall      = en_q & ~enable;
    assign last         = (ptr_q == LAST_ADDR);
    assign fv_after_ack = fv_q & ~frame_ack;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bank_d  = bank_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wbank_d = wbank_q;
        wdata_d = wdata_q;
        fv_d    = fv_after_ack;
        fbank_d = fbank_q;
        ovr_d   = en_fall ? 1'b0 : ovr_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = SYNC;
            end
            SYNC, FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    addr_d  = '0;
                end else if (se) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wbank_d = bank_q;
                    wdata_d = fmt_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = FILL;
                    if (last) begin
                        ptr_d = '0;
                        // An ack arriving with the final write frees the other bank first.
                        if (!fv_after_ack) begin
                            fv_d    = 1'b1;
                            fbank_d = bank_q;
                            bank_d  = ~bank_q;
                        end else begin
                            ovr_d   = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    addr_d  = '0;
                end else if (fv_q && frame_ack) begin
                    fv_d    = 1'b1;
                    fbank_d = bank_q;
                    bank_d  = ~bank_q;
                    ptr_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lrck_q  <= 1'b0;
            en_q    <= 1'b0;
            ptr_q   <= '0;
            bank_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wbank_q <= 1'b0;
            wdata_q <= '0;
            fv_q    <= 1'b0;
            fbank_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lrck_q  <= lrck;
            en_q    <= enable;
            ptr_q   <= ptr_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wbank_q <= wbank_d;
            wdata_q <= wdata_d;
            fv_q    <= fv_d;
            fbank_q <= fbank_d;
            ovr_q   <= ovr_d;
        end
    end

    assign buf_we      = we_q;
    assign buf_bank    = wbank_q;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign frame_valid = fv_q;
    assign frame_bank  = fbank_q;
    assign overrun     = ovr_q;

`ifdef I2S_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (en_fall)
            drop_cnt_d = '0;
        else if (state_q == HOLD && enable && se && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed testbench for i2s_capture_ctrl with an 8-sample frame.
// Define I2S_CAPTURE_DROP_CNT_EN to also check the drop counter.
module tb_i2s_capture_ctrl;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset, enable, lrck, frame_ack;
    logic [1:0]    chan_sel;
    logic [23:0]   left, right;
    logic          buf_we, buf_bank, frame_valid, frame_bank, overrun;
    logic [AW-1:0] buf_addr;
    logic [15:0]   buf_wdata;
`ifdef I2S_CAPTURE_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic          we_s, bank_s, wa_s;
    logic [AW-1:0] addr_s;
    logic [15:0]   wd_s;

    i2s_capture_ctrl #(.N_SAMPLES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .chan_sel    (chan_sel),
        .lrck        (lrck),
        .left        (left),
        .right       (right),
        .buf_we      (buf_we),
        .buf_bank    (buf_bank),
        .buf_addr    (buf_addr),
        .buf_wdata   (buf_wdata),
        .frame_valid (frame_valid),
        .frame_bank  (frame_bank),
        .frame_ack   (frame_ack),
        .overrun     (overrun)
`ifdef I2S_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lrck period (8 clk); captures the cycle after the lrck fall and the one after that.
    task automatic do_se(input logic [23:0] l, input logic [23:0] r, input logic ack,
                         output logic we, output logic [AW-1:0] addr, output logic bank,
                         output logic [15:0] wd, output logic we_after);
        left  = l;
        right = r;
        lrck  = 1'b1;
        repeat (4) tick();
        lrck      = 1'b0;
        frame_ack = ack;
        tick();
        frame_ack = 1'b0;
        we   = buf_we;
        addr = buf_addr;
        bank = buf_bank;
        wd   = buf_wdata;
        tick();
        we_after = buf_we;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; lrck = 1'b0; frame_ack = 1'b0;
        chan_sel = 2'd0; left = '0; right = '0;
        repeat (3) tick();
        total++;
        if ({buf_we, buf_bank, buf_addr, buf_wdata, frame_valid, frame_bank, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got we=%b bank=%b addr=%0d data=%h fv=%b fb=%b ovr=%b exp all 0",
                     buf_we, buf_bank, buf_addr, buf_wdata, frame_valid, frame_bank, overrun);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        enable   = 1'b1;
        chan_sel = 2'd0;
        for (int i = 0; i < N; i++) begin
            do_se(24'h123456, 24'hABCDEF, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
            total++;
            if (we_s !== 1'b1 || addr_s !== AW'(i) || bank_s !== 1'b0 || wd_s !== 16'h1234) begin
                bad++;
                $display("FAIL fill_write[%0d] got we=%b addr=%0d bank=%b data=%h exp we=1 addr=%0d bank=0 data=1234",
                         i, we_s, addr_s, bank_s, wd_s, i);
            end
            total++;
            if (wa_s !== 1'b0) begin
                bad++;
                $display("FAIL fill_we_width[%0d] got=%b exp=0", i, wa_s);
            end
            if (i == N - 2) begin
                total++;
                if (frame_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_fv_early got=%b exp=0", frame_valid);
                end
            end
        end
        total++;
        if (frame_valid !== 1'b1 || frame_bank !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL fill_frame got fv=%b fb=%b ovr=%b exp fv=1 fb=0 ovr=0", frame_valid, frame_bank, overrun);
        end
    endtask

    task automatic test_mono();
        logic [1:0]  sel_t [4] = '{2'd2, 2'd2, 2'd1, 2'd3};
        logic [23:0] l_t   [4] = '{24'h7FFFFF, 24'h800000, 24'h000000, 24'h876543};
        logic [23:0] r_t   [4] = '{24'h000001, 24'h800000, 24'hABCDEF, 24'h000000};
        logic [15:0] exp_t [4] = '{16'h4000, 16'h8000, 16'hABCD, 16'h8765};
        for (int i = 0; i < 4; i++) begin
            chan_sel = sel_t[i];
            do_se(l_t[i], r_t[i], 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
            total++;
            if (we_s !== 1'b1 || addr_s !== AW'(i) || bank_s !== 1'b1 || wd_s !== exp_t[i]) begin
                bad++;
                $display("FAIL fmt_write[%0d] got we=%b addr=%0d bank=%b data=%h exp we=1 addr=%0d bank=1 data=%h",
                         i, we_s, addr_s, bank_s, wd_s, i, exp_t[i]);
            end
        end
    endtask

    task automatic test_ack_same_cycle();
        chan_sel = 2'd0;
        for (int i = 4; i < N; i++) begin
            do_se(24'h2468AC, 24'h0, (i == N - 1), we_s, addr_s, bank_s, wd_s, wa_s);
            total++;
            if (we_s !== 1'b1 || addr_s !== AW'(i) || bank_s !== 1'b1 || wd_s !== 16'h2468) begin
                bad++;
                $display("FAIL ackc_write[%0d] got we=%b addr=%0d bank=%b data=%h exp we=1 addr=%0d bank=1 data=2468",
                         i, we_s, addr_s, bank_s, wd_s, i);
            end
        end
        total++;
        if (overrun !== 1'b0 || frame_valid !== 1'b1 || frame_bank !== 1'b1) begin
            bad++;
            $display("FAIL ackc_frame got ovr=%b fv=%b fb=%b exp ovr=0 fv=1 fb=1", overrun, frame_valid, frame_bank);
        end
        do_se(24'h135790, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        total++;
        if (we_s !== 1'b1 || addr_s !== 3'd0 || bank_s !== 1'b0 || wd_s !== 16'h1357) begin
            bad++;
            $display("FAIL ackc_next got we=%b addr=%0d bank=%b data=%h exp we=1 addr=0 bank=0 data=1357",
                     we_s, addr_s, bank_s, wd_s);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i < N; i++) begin
            do_se(24'h55AA33, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
            total++;
            if (we_s !== 1'b1 || addr_s !== AW'(i) || bank_s !== 1'b0) begin
                bad++;
                $display("FAIL ovr_write[%0d] got we=%b addr=%0d bank=%b exp we=1 addr=%0d bank=0",
                         i, we_s, addr_s, bank_s, i);
            end
            if (i == N - 2) begin
                total++;
                if (overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL ovr_early got=%b exp=0", overrun);
                end
            end
        end
        total++;
        if (overrun !== 1'b1 || frame_valid !== 1'b1 || frame_bank !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set got ovr=%b fv=%b fb=%b exp ovr=1 fv=1 fb=1", overrun, frame_valid, frame_bank);
        end
        for (int i = 0; i < 2; i++) begin
            do_se(24'h111111, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
            total++;
            if (we_s !== 1'b0) begin
                bad++;
                $display("FAIL hold_drop[%0d] got we=%b exp=0", i, we_s);
            end
`ifdef I2S_CAPTURE_DROP_CNT_EN
            total++;
            if (drop_cnt !== 16'(i + 1)) begin
                bad++;
                $display("FAIL drop_cnt[%0d] got=%0d exp=%0d", i, drop_cnt, i + 1);
            end
`endif
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        tick();
        total++;
        if (frame_valid !== 1'b1 || frame_bank !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL hold_ack got fv=%b fb=%b ovr=%b exp fv=1 fb=0 ovr=1", frame_valid, frame_bank, overrun);
        end
        do_se(24'hFEDCBA, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        total++;
        if (we_s !== 1'b1 || addr_s !== 3'd0 || bank_s !== 1'b1 || wd_s !== 16'hFEDC) begin
            bad++;
            $display("FAIL hold_resume got we=%b addr=%0d bank=%b data=%h exp we=1 addr=0 bank=1 data=fedc",
                     we_s, addr_s, bank_s, wd_s);
        end
    endtask

    task automatic test_enable_abort();
        for (int i = 1; i < 4; i++)
            do_se(24'h0A0B0C, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        enable = 1'b0;
        repeat (2) tick();
        total++;
        if (overrun !== 1'b0 || buf_addr !== 3'd0 || frame_valid !== 1'b1 || frame_bank !== 1'b0 || buf_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got ovr=%b addr=%0d fv=%b fb=%b we=%b exp ovr=0 addr=0 fv=1 fb=0 we=0",
                     overrun, buf_addr, frame_valid, frame_bank, buf_we);
        end
`ifdef I2S_CAPTURE_DROP_CNT_EN
        total++;
        if (drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL abort_drop_cnt got=%0d exp=0", drop_cnt);
        end
`endif
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (buf_we !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_write[%0d] got=%b exp=0", i, buf_we);
            end
        end
        do_se(24'h3C3C3C, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        total++;
        if (we_s !== 1'b1 || addr_s !== 3'd0 || bank_s !== 1'b1 || wd_s !== 16'h3C3C || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart got we=%b addr=%0d bank=%b data=%h fv=%b exp we=1 addr=0 bank=1 data=3c3c fv=1",
                     we_s, addr_s, bank_s, wd_s, frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 6; i++)
            do_se(24'h777777, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        total++;
        if (addr_s !== 3'd5) begin
            bad++;
            $display("FAIL rmid_pre_addr got=%0d exp=5", addr_s);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({buf_we, buf_bank, buf_addr, buf_wdata, frame_valid, frame_bank, overrun} !== '0) begin
            bad++;
            $display("FAIL rmid_outputs got we=%b bank=%b addr=%0d data=%h fv=%b fb=%b ovr=%b exp all 0",
                     buf_we, buf_bank, buf_addr, buf_wdata, frame_valid, frame_bank, overrun);
        end
        reset = 1'b0;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (buf_we !== 1'b0 || frame_valid !== 1'b0) begin
                bad++;
                $display("FAIL rmid_idle[%0d] got we=%b fv=%b exp we=0 fv=0", i, buf_we, frame_valid);
            end
        end
        do_se(24'h0F0F0F, 24'h0, 1'b0, we_s, addr_s, bank_s, wd_s, wa_s);
        total++;
        if (we_s !== 1'b1 || addr_s !== 3'd0 || bank_s !== 1'b0 || wd_s !== 16'h0F0F) begin
            bad++;
            $display("FAIL rmid_restart got we=%b addr=%0d bank=%b data=%h exp we=1 addr=0 bank=0 data=0f0f",
                     we_s, addr_s, bank_s, wd_s);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_mono();
        test_ack_same_cycle();
        test_overrun();
        test_enable_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
